// File: rtl/fetch_sequencer.sv
// Multi-buffer tile fetch sequencer: turns "fetch next tile of buffer b" commands
// into BRAM read bursts, tracking read-data valid across a fixed BRAM latency.
module fetch_sequencer #(
  parameter int unsigned NUM_BUFS     = 3,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned PTR_WIDTH    = 9,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned BRAM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [SEL_WIDTH-1:0]           cmd_buf,
  input  logic [CNT_WIDTH-1:0]           cmd_len,
  input  logic [NUM_BUFS*ADDR_WIDTH-1:0] base_addr_flat,
  input  logic [NUM_BUFS*PTR_WIDTH-1:0]  buf_tiles_flat,
  input  logic                           clear_ptrs,
  input  logic                           abort,
  input  logic                           stall,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  output logic                           bram_en,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic [SEL_WIDTH-1:0]           rd_buf,
  output logic                           fetch_done,
  output logic                           cmd_err,
  output logic                           busy
);

  localparam int unsigned PROD_WIDTH = PTR_WIDTH + CNT_WIDTH;
  localparam int unsigned LAT        = BRAM_LATENCY;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  buf_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  offset_q;
  logic [ADDR_WIDTH-1:0] tile_base_q;
  logic                  err_q;
  logic [PTR_WIDTH-1:0]  ptr_q [NUM_BUFS];
  logic [LAT-1:0]        pipe_en_q;
  logic [LAT-1:0]        pipe_last_q;

  logic                  accept;
  logic                  cmd_bad;
  logic                  abort_act;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [PTR_WIDTH-1:0]  sel_ptr;
  logic [PTR_WIDTH-1:0]  done_ptr;
  logic [PTR_WIDTH-1:0]  done_tiles;
  logic [PTR_WIDTH-1:0]  done_inc;
  logic [PROD_WIDTH-1:0] tile_off;

  // Per-buffer lookups; an out-of-range index reads as zero.
  always_comb begin
    sel_base   = '0;
    sel_ptr    = '0;
    done_ptr   = '0;
    done_tiles = '0;
    for (int i = 0; i < int'(NUM_BUFS); i++) begin
      if (cmd_buf == SEL_WIDTH'(i)) begin
        sel_base = base_addr_flat[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_ptr  = ptr_q[i];
      end
      if (buf_q == SEL_WIDTH'(i)) begin
        done_ptr   = ptr_q[i];
        done_tiles = buf_tiles_flat[i*PTR_WIDTH +: PTR_WIDTH];
      end
    end
  end

  assign accept     = cmd_valid && (state_q == IDLE);
  assign cmd_bad    = (cmd_len == '0) || (32'(cmd_buf) >= NUM_BUFS);
  assign abort_act  = abort && ((state_q == FETCH) || (state_q == DRAIN));
  assign tile_off   = PROD_WIDTH'(sel_ptr) * PROD_WIDTH'(cmd_len);
  assign done_inc   = done_ptr + PTR_WIDTH'(1);
  assign issue_last = bram_en && (offset_q == (len_q - CNT_WIDTH'(1)));

  // Issue is same-cycle with stall so a stalled BRAM port never sees a request.
  assign bram_en    = (state_q == FETCH) && !stall && !abort;
  assign bram_addr  = tile_base_q + ADDR_WIDTH'(offset_q);
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rd_valid   = pipe_en_q[LAT-1];
  assign rd_last    = pipe_last_q[LAT-1];
  assign rd_buf     = buf_q;
  assign fetch_done = (state_q == DONE);
  assign cmd_err    = (state_q == DONE) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_bad ? DONE : FETCH;
      FETCH:   if (abort) state_d = IDLE;
               else if (issue_last) state_d = DRAIN;
      // The last tag is at the pipeline output this cycle and leaves on this edge.
      DRAIN:   if (abort) state_d = IDLE;
               else if (pipe_last_q[LAT-1]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      len_q       <= '0;
      offset_q    <= '0;
      tile_base_q <= '0;
      err_q       <= 1'b0;
      pipe_en_q   <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < int'(NUM_BUFS); i++) ptr_q[i] <= '0;
    end else begin
      if (accept) begin
        buf_q       <= cmd_buf;
        len_q       <= cmd_len;
        tile_base_q <= sel_base + ADDR_WIDTH'(tile_off);
        err_q       <= cmd_bad;
        offset_q    <= '0;
      end else if (bram_en) begin
        offset_q <= offset_q + CNT_WIDTH'(1);
      end

      if (abort_act) begin
        pipe_en_q   <= '0;
        pipe_last_q <= '0;
      end else begin
        pipe_en_q   <= LAT'({pipe_en_q, bram_en});
        pipe_last_q <= LAT'({pipe_last_q, issue_last});
      end

      // clear_ptrs wins over the completion increment.
      for (int i = 0; i < int'(NUM_BUFS); i++) begin
        if (clear_ptrs)
          ptr_q[i] <= '0;
        else if ((state_q == DONE) && !err_q && (buf_q == SEL_WIDTH'(i)))
          ptr_q[i] <= (done_inc == done_tiles) ? '0 : done_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level reference model predicts
// every issue, read-valid and completion; a monitor pops and compares them.
module tb_fetch_sequencer;

  localparam int NB  = 3;
  localparam int SW  = 2;
  localparam int AW  = 11;
  localparam int PW  = 9;
  localparam int CW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [SW-1:0] cmd_buf = '0;
  logic [CW-1:0] cmd_len = '0;
  logic [NB*AW-1:0] base_addr_flat;
  logic [NB*PW-1:0] buf_tiles_flat;
  logic          clear_ptrs = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          rd_valid;
  logic          rd_last;
  logic [SW-1:0] rd_buf;
  logic          fetch_done;
  logic          cmd_err;
  logic          busy;

  logic [AW-1:0] base_m [NB];
  logic [PW-1:0] tiles_m [NB];
  int            ptr_m [NB];

  typedef struct { int cyc; int val; int aux; } exp_t;
  exp_t addr_q[$];
  exp_t rd_q[$];
  exp_t done_q[$];

  bit stall_plan [96];
  bit clear_plan [96];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;

  assign base_addr_flat = {base_m[2], base_m[1], base_m[0]};
  assign buf_tiles_flat = {tiles_m[2], tiles_m[1], tiles_m[0]};

  fetch_sequencer #(
    .NUM_BUFS(NB), .SEL_WIDTH(SW), .ADDR_WIDTH(AW),
    .PTR_WIDTH(PW), .CNT_WIDTH(CW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_buf(cmd_buf), .cmd_len(cmd_len), .base_addr_flat(base_addr_flat),
    .buf_tiles_flat(buf_tiles_flat), .clear_ptrs(clear_ptrs), .abort(abort),
    .stall(stall), .bram_addr(bram_addr), .bram_en(bram_en), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_buf(rd_buf), .fetch_done(fetch_done), .cmd_err(cmd_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plan_zero();
    for (int j = 0; j < 96; j++) begin
      stall_plan[j] = 1'b0;
      clear_plan[j] = 1'b0;
    end
  endtask

  task automatic plan_random(input int stall_pct, input int clr_pct);
    for (int j = 0; j < 96; j++) begin
      stall_plan[j] = (j < 24) && ($urandom_range(0, 99) < stall_pct);
      clear_plan[j] = ($urandom_range(0, 99) < clr_pct);
    end
  endtask

  // Predict one command from the behavioural rules, then drive it cycle by cycle.
  task automatic run_cmd(input int b, input int len, input int abort_j, input bit clr_done);
    int   t0, issued, last_j, done_j, ready_j, ab_c, tbase, nxt;
    bit   bad, aborted, clr;
    int   iss[$];
    exp_t e;
    chk("cmd_ready_at_accept", cmd_ready, 1);
    chk("busy_at_accept", busy, 0);
    t0 = cyc;
    bad = (len == 0) || (b >= NB);
    aborted = 1'b0;
    last_j = -1;
    done_j = -1;
    ready_j = 2;
    ab_c = 0;
    tbase = 0;
    if (bad) begin
      done_j = 1;
      ready_j = 2;
    end else begin
      tbase = (int'(base_m[b]) + ptr_m[b] * len) % 2048;
      issued = 0;
      for (int j = 1; j < 96 && issued < len && !aborted; j++) begin
        if (j == abort_j) begin
          aborted = 1'b1;
          ab_c = t0 + j;
          ready_j = j + 1;
        end else if (!stall_plan[j]) begin
          e.cyc = t0 + j; e.val = (tbase + issued) % 2048; e.aux = 0;
          addr_q.push_back(e);
          iss.push_back(j);
          issued++;
          if (issued == len) last_j = j;
        end
      end
      if (!aborted) begin
        if (abort_j > last_j && abort_j <= last_j + LAT) begin
          aborted = 1'b1;
          ab_c = t0 + abort_j;
          ready_j = abort_j + 1;
        end else begin
          done_j = last_j + LAT + 1;
          ready_j = done_j + 1;
        end
      end
      foreach (iss[k]) begin
        if (!aborted || (t0 + iss[k] + LAT <= ab_c)) begin
          e.cyc = t0 + iss[k] + LAT; e.val = b; e.aux = (k == len - 1) ? 1 : 0;
          rd_q.push_back(e);
        end
      end
    end
    if (done_j >= 0) begin
      e.cyc = t0 + done_j; e.val = bad ? 1 : 0; e.aux = 0;
      done_q.push_back(e);
    end
    for (int j = 0; j < ready_j; j++) begin
      clr = clear_plan[j] || (clr_done && j == done_j);
      cmd_valid  = (j == 0);
      cmd_buf    = SW'(b);
      cmd_len    = CW'(len);
      stall      = stall_plan[j];
      abort      = (j == abort_j);
      clear_ptrs = clr;
      if (j == done_j && !bad && !clr) begin
        nxt = (ptr_m[b] + 1) % 512;
        ptr_m[b] = (nxt == int'(tiles_m[b])) ? 0 : nxt;
      end
      if (clr) for (int k = 0; k < NB; k++) ptr_m[k] = 0;
      step();
    end
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    clear_ptrs = 1'b0;
  endtask

  // Monitor: compare every DUT output event with the head of its queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (bram_en === 1'b1) begin
          if (addr_q.size() == 0) chk("spurious_bram_en", bram_en, 0);
          else begin
            e = addr_q.pop_front();
            chk("issue_cycle", cyc, e.cyc);
            chk("bram_addr", bram_addr, e.val);
          end
        end
        if (rd_valid === 1'b1) begin
          if (rd_q.size() == 0) chk("spurious_rd_valid", rd_valid, 0);
          else begin
            e = rd_q.pop_front();
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_buf", rd_buf, e.val);
            chk("rd_last", rd_last, e.aux);
          end
        end
        if (fetch_done === 1'b1) begin
          if (done_q.size() == 0) chk("spurious_fetch_done", fetch_done, 0);
          else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("cmd_err", cmd_err, e.val);
          end
        end
        if (cmd_err === 1'b1) chk("cmd_err_with_done", fetch_done, 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, len, ab, idx, t_exp;
    base_m[0] = 11'd0;  base_m[1] = 11'd4;  base_m[2] = 11'd772;
    tiles_m[0] = 9'd3;  tiles_m[1] = 9'd0;  tiles_m[2] = 9'd0;
    for (int k = 0; k < NB; k++) ptr_m[k] = 0;
    plan_zero();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bram_addr", bram_addr, 0);
    chk("reset_bram_en", bram_en, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_rd_buf", rd_buf, 0);
    chk("reset_fetch_done", fetch_done, 0);
    chk("reset_cmd_err", cmd_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    run_cmd(1, 2, -1, 0);              // addresses 4,5
    run_cmd(1, 2, -1, 0);              // addresses 6,7
    for (int n = 0; n < 4; n++) run_cmd(0, 4, -1, 0);   // bases 0,4,8,0
    stall_plan[2] = 1'b1; stall_plan[3] = 1'b1;
    run_cmd(2, 3, -1, 0);              // 772 then 2-cycle gap then 773,774
    plan_zero();
    run_cmd(1, 5, 3, 0);               // abort after second issue
    run_cmd(1, 5, -1, 0);              // same tile base again
    run_cmd(1, 0, -1, 0);              // zero length
    run_cmd(3, 4, -1, 0);              // buffer out of range
    run_cmd(1, 2, -1, 0);              // pointer untouched by errors
    clear_plan[0] = 1'b1;
    run_cmd(1, 2, -1, 0);              // clear at accept keeps latched base
    plan_zero();
    run_cmd(1, 2, -1, 1);              // clear coincident with done
    run_cmd(1, 2, -1, 0);              // restarts at address 4
    run_cmd(2, 3, 5, 0);               // abort in last drain cycle
    run_cmd(2, 3, 0, 0);               // abort in idle is ignored
    run_cmd(0, 2, 5, 0);               // abort in done is ignored

    // Asynchronous reset in the middle of a burst.
    mon_en = 1'b0;
    t_exp = (int'(base_m[2]) + ptr_m[2] * 8 + 1) % 2048;
    cmd_valid = 1'b1; cmd_buf = 2'd2; cmd_len = 8'd8;
    step();
    cmd_valid = 1'b0;
    step();
    chk("pre_reset_bram_en", bram_en, 1);
    chk("pre_reset_bram_addr", bram_addr, t_exp);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_bram_en", bram_en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_cmd_ready", cmd_ready, 1);
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_fetch_done", fetch_done, 0);
    for (int k = 0; k < NB; k++) ptr_m[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    run_cmd(2, 3, -1, 0);              // pointer restarted at zero

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NB - 1);
        base_m[idx]  = AW'($urandom);
        tiles_m[idx] = PW'($urandom_range(0, 6));
      end
      b   = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NB - 1);
      len = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + LAT + 2) : -1;
      plan_random(25, 4);
      run_cmd(b, len, ab, ($urandom_range(0, 7) == 0));
      plan_zero();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (8) step();
    chk("addr_queue_drained", addr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-buffer tile fetch sequencer that turns "fetch next tile of buffer b" commands into BRAM read-address bursts. It sits between the arbiter control FSM and the shared operand BRAM. Compared with the fixed three-buffer fetch block, it adds:

- a run-time base address per buffer;
- a variable tile length per command;
- per-buffer pointer wrap;
- a ready/valid command handshake and BRAM stall back-pressure;
- read-data valid tracking for a fixed BRAM latency;
- abort and error reporting.

## Interface
Parameters:
- NUM_BUFS, 3, number of logical buffers (≥1)
- SEL_WIDTH, 2, width of cmd_buf (2^SEL_WIDTH ≥ NUM_BUFS)
- ADDR_WIDTH, 11, BRAM address width
- PTR_WIDTH, 9, per-buffer tile pointer width
- CNT_WIDTH, 8, tile length / offset width
- BRAM_LATENCY, 1, cycles from bram_en to data at BRAM output (≥1)

Ports (clock and reset: clk; reset rst_n, asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_buf  in  SEL_WIDTH  target buffer index
- cmd_len  in  CNT_WIDTH  words per tile for this command
- base_addr_flat  in  NUM_BUFS*ADDR_WIDTH  base of buffer i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- buf_tiles_flat  in  NUM_BUFS*PTR_WIDTH  tiles per buffer before wrap; 0 = wrap at 2^PTR_WIDTH
- clear_ptrs  in  1  zero all tile pointers
- abort  in  1  cancel the in-flight command
- stall  in  1  BRAM port busy; hold issue
- bram_addr  out  ADDR_WIDTH  read address, valid only when bram_en=1
- bram_en  out  1  read enable
- rd_valid  out  1  BRAM output data valid this cycle
- rd_last  out  1  qualifies the final rd_valid of a tile
- rd_buf  out  SEL_WIDTH  buffer index of the current command
- fetch_done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse with fetch_done on a rejected command
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- **Accept:** a command is accepted on cmd_valid && cmd_ready in IDLE. In that cycle the block latches:
  - buf_q = cmd_buf;
  - len_q = cmd_len;
  - tile_base = base[cmd_buf] + ptr[cmd_buf]*cmd_len, computed at full PTR_WIDTH+CNT_WIDTH width then truncated mod 2^ADDR_WIDTH.
- **Error commands:** cmd_len == 0 or cmd_buf ≥ NUM_BUFS go IDLE→DONE directly with cmd_err=1. No bram_en is issued and the pointer is unchanged.
- **Other commands:** go IDLE→FETCH.
- **FETCH:**
  - bram_en = !stall; bram_addr = tile_base + offset (mod 2^ADDR_WIDTH).
  - offset starts at 0 and increments only on cycles with bram_en=1.
  - When offset == len_q−1 issues, the next state is DRAIN.
- **Read tracking:** a BRAM_LATENCY-deep shift pipeline carries (en, last) tags.
  - rd_valid and rd_last appear exactly BRAM_LATENCY cycles after the matching bram_en.
  - The pipeline keeps shifting regardless of stall.
- **DRAIN:** wait until the last tag has exited the pipeline, then go to DONE.
- **DONE:**
  - fetch_done=1 for one cycle.
  - ptr[buf_q] ← (ptr+1 == buf_tiles[buf_q]) ? 0 : ptr+1; skipped for error commands.
  - Next state is IDLE.
- **clear_ptrs:** all pointers become 0 on the next edge. It overrides a simultaneous DONE increment. It does not alter a tile_base already latched.
- **abort:**
  - Applies in FETCH or DRAIN; ignored in IDLE and DONE.
  - bram_en is forced 0 in the abort cycle and the pipeline is flushed, so rd_valid=0 from the next cycle.
  - Next state is IDLE: no fetch_done, pointer unchanged.
- rd_buf = buf_q in all states.

## Timing
- Reset values:
  - bram_addr = 0, bram_en = 0, rd_valid = 0, rd_last = 0, rd_buf = 0;
  - fetch_done = 0, cmd_err = 0, busy = 0;
  - cmd_ready = 1 (IDLE);
  - all pointers, offset, tile_base and the pipeline = 0.
- No-stall latency, with acceptance at cycle T and L = BRAM_LATENCY:
  - bram_en high in cycles T+1 … T+len;
  - rd_valid in T+1+L … T+len+L;
  - fetch_done in T+len+L+1;
  - cmd_ready high again in T+len+L+2.
- Each stall cycle during FETCH adds one cycle to every later event.
- Error command accepted at T: fetch_done and cmd_err in T+1, cmd_ready in T+2.
- Reset asserted mid-operation returns the block to IDLE immediately, with all state cleared and no done pulse.

## Test plan
- Bases {0,4,772}, L=1, buf 1, len 2, twice → addresses 4,5 then 6,7; rd_last on second rd_valid; fetch_done at T+4 each.
- Buf 0, buf_tiles=3, len 4, four commands → tile bases 0,4,8,0 (pointer wraps).
- Buf 2, len 3, stall high for 2 cycles after the first issue → addresses 772,773,774 with a 2-cycle gap; fetch_done at T+7.
- L=2, abort in the cycle after the second issue of a len 5 tile → no further bram_en or rd_valid, no fetch_done, next command reuses the same tile_base.
- cmd_len=0 and cmd_buf=3 → fetch_done+cmd_err at T+1, no bram_en, pointer unchanged.
- clear_ptrs coincident with DONE after buf 1 tile 0 → next buf 1 fetch starts at address 4.
